// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: GREEN/YELLOW/RED sequencer with BCD countdown and pedestrian-request shortening.
module traffic_phase_controller #(
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 5,
    parameter int RED_TIME    = 20,
    parameter int PED_SHORT   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       ped_req,
    output logic       light_green,
    output logic       light_yellow,
    output logic       light_red,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [1:0] dozens,
    output logic [3:0] units,
    output logic       phase_done
);
    generate
        if (GREEN_TIME < 1 || GREEN_TIME > 30 || YELLOW_TIME < 1 || YELLOW_TIME > 30 ||
            RED_TIME < 1 || RED_TIME > 30 || PED_SHORT < 1 || PED_SHORT > GREEN_TIME) begin : g_bad_param
            $error("traffic_phase_controller: phase length parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {RED, GREEN, YELLOW} phase_t;

    function automatic logic [5:0] bcd(input int n);
        return {2'(n / 10), 4'(n % 10)};
    endfunction

    phase_t     state, state_n;
    logic [1:0] dozens_n;
    logic [3:0] units_n;
    logic       pending_n, done_n;
    logic       run, last, trunc;
    logic [4:0] remaining;

    assign remaining = 5'(dozens) * 5'd10 + 5'(units);
    assign run       = enable & tick;
    assign last      = {dozens, units} == 6'h01;
    // A tick always takes priority; shortening only happens on tick-free cycles.
    assign trunc     = enable & !tick & ped_pending & (state == GREEN) & (remaining > 5'(PED_SHORT));

    always_comb begin
        state_n             = state;
        {dozens_n, units_n} = {dozens, units};
        done_n              = 1'b0;
        pending_n           = ped_pending | (ped_req & (state != RED));
        if (run & last) begin
            done_n = 1'b1;
            case (state)
                RED: begin
                    state_n             = GREEN;
                    {dozens_n, units_n} = bcd(GREEN_TIME);
                end
                GREEN: begin
                    state_n             = YELLOW;
                    {dozens_n, units_n} = bcd(YELLOW_TIME);
                end
                default: begin
                    state_n             = RED;
                    {dozens_n, units_n} = bcd(RED_TIME);
                    pending_n           = 1'b0;
                end
            endcase
        end else if (run) begin
            units_n  = units == 4'd0 ? 4'd9 : units - 4'd1;
            dozens_n = units == 4'd0 ? dozens - 2'd1 : dozens;
        end else if (trunc) begin
            {dozens_n, units_n} = bcd(PED_SHORT);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= RED;
            {dozens, units} <= bcd(RED_TIME);
            ped_pending     <= 1'b0;
            phase_done      <= 1'b0;
        end else begin
            state           <= state_n;
            {dozens, units} <= {dozens_n, units_n};
            ped_pending     <= pending_n;
            phase_done      <= done_n;
        end
    end

    assign light_red    = state == RED;
    assign light_green  = state == GREEN;
    assign light_yellow = state == YELLOW;
    assign ped_walk     = state == RED;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: directed checks of phase sequencing, countdown, truncation and freeze.
module tb_traffic_phase_controller;
    logic       clock, reset, tick, enable, ped_req;
    logic       light_green, light_yellow, light_red, ped_walk, ped_pending, phase_done;
    logic [1:0] dozens;
    logic [3:0] units;
    int         checks = 0;
    int         errors = 0;

    traffic_phase_controller dut (
        .clock(clock), .reset(reset), .tick(tick), .enable(enable), .ped_req(ped_req),
        .light_green(light_green), .light_yellow(light_yellow), .light_red(light_red),
        .ped_walk(ped_walk), .ped_pending(ped_pending), .dozens(dozens), .units(units),
        .phase_done(phase_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_ticks(input int k);
        tick = 1'b1;
        repeat (k) step();
        tick = 1'b0;
    endtask

    function automatic logic [7:0] tobcd(input int n);
        return 8'({2'(n / 10), 4'(n % 10)});
    endfunction

    function automatic logic [7:0] disp();
        return 8'({dozens, units});
    endfunction

    function automatic logic [7:0] lamps();
        return 8'({light_red, light_yellow, light_green});
    endfunction

    initial begin
        int ph, n, pulses, len[3];
        logic exp_done;
        len = '{20, 30, 5};
        reset = 1'b1; tick = 1'b0; enable = 1'b1; ped_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_disp", disp(), 8'h20);
        chk("rst_lamps", lamps(), 8'b100);
        chk("rst_walk", 8'(ped_walk), 8'd1);
        chk("rst_pend", 8'(ped_pending), 8'd0);
        chk("rst_done", 8'(phase_done), 8'd0);

        run_ticks(33);
        chk("g17_disp", disp(), 8'h17);
        chk("g17_lamps", lamps(), 8'b001);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        chk("g17_pend", 8'(ped_pending), 8'd1);
        reset = 1'b1; #2;
        chk("arst_disp", disp(), 8'h20);
        chk("arst_lamps", lamps(), 8'b100);
        chk("arst_walk", 8'(ped_walk), 8'd1);
        chk("arst_pend", 8'(ped_pending), 8'd0);
        chk("arst_done", 8'(phase_done), 8'd0);
        @(posedge clock); #1 reset = 1'b0;
        chk("arst_done2", 8'(phase_done), 8'd0);

        ph = 0; n = 20; pulses = 0;
        tick = 1'b1;
        for (int i = 0; i < 55; i++) begin
            step();
            if (n == 1) begin
                ph = (ph + 1) % 3; n = len[ph]; exp_done = 1'b1;
            end else begin
                n--; exp_done = 1'b0;
            end
            chk("cyc_disp", disp(), tobcd(n));
            chk("cyc_lamps", lamps(), ph == 0 ? 8'b100 : ph == 1 ? 8'b001 : 8'b010);
            chk("cyc_walk", 8'(ped_walk), ph == 0 ? 8'd1 : 8'd0);
            chk("cyc_done", 8'(phase_done), 8'(exp_done));
            pulses += int'(phase_done);
        end
        tick = 1'b0;
        chk("cyc_pulses", 8'(pulses), 8'd3);

        run_ticks(25);
        chk("tr_disp25", disp(), 8'h25);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        chk("tr_pend", 8'(ped_pending), 8'd1);
        step();
        chk("tr_disp10", disp(), 8'h10);
        chk("tr_pend2", 8'(ped_pending), 8'd1);
        run_ticks(9);
        chk("tr_disp01", disp(), 8'h01);
        chk("tr_green", lamps(), 8'b001);
        run_ticks(1);
        chk("tr_yel", lamps(), 8'b010);
        chk("tr_yel05", disp(), 8'h05);
        chk("tr_yel_done", 8'(phase_done), 8'd1);
        run_ticks(4);
        chk("tr_yel_pend", 8'(ped_pending), 8'd1);
        run_ticks(1);
        chk("tr_red", lamps(), 8'b100);
        chk("tr_walk", 8'(ped_walk), 8'd1);
        chk("tr_red_pend", 8'(ped_pending), 8'd0);
        chk("tr_red20", disp(), 8'h20);

        run_ticks(43);
        chk("nt_disp07", disp(), 8'h07);
        ped_req = 1'b1; step(); ped_req = 1'b0;
        step();
        chk("nt_hold07", disp(), 8'h07);
        chk("nt_pend", 8'(ped_pending), 8'd1);
        run_ticks(1);
        chk("nt_disp06", disp(), 8'h06);
        run_ticks(1);
        chk("nt_disp05", disp(), 8'h05);
        run_ticks(5);
        chk("nt_yel", lamps(), 8'b010);
        run_ticks(5);
        chk("nt_red", lamps(), 8'b100);
        chk("nt_red_pend", 8'(ped_pending), 8'd0);

        run_ticks(25);
        chk("co_disp25", disp(), 8'h25);
        ped_req = 1'b1;
        run_ticks(1);
        ped_req = 1'b0;
        chk("co_disp24", disp(), 8'h24);
        chk("co_pend", 8'(ped_pending), 8'd1);
        run_ticks(1);
        chk("co_disp23", disp(), 8'h23);
        step();
        chk("co_disp10", disp(), 8'h10);
        run_ticks(15);
        chk("co_red", lamps(), 8'b100);
        chk("co_red_pend", 8'(ped_pending), 8'd0);

        run_ticks(25);
        chk("fr_disp25", disp(), 8'h25);
        enable = 1'b0; tick = 1'b1;
        for (int i = 0; i < 50; i++) begin
            ped_req = (i % 2) == 1;
            step();
            chk("fr_disp", disp(), 8'h25);
            chk("fr_lamps", lamps(), 8'b001);
            chk("fr_done", 8'(phase_done), 8'd0);
        end
        tick = 1'b0; ped_req = 1'b0;
        step();
        chk("fr_pend", 8'(ped_pending), 8'd1);
        chk("fr_still25", disp(), 8'h25);
        enable = 1'b1;
        step();
        chk("fr_trunc10", disp(), 8'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
